// File: rtl/ocr_result_filo.sv
// LIFO buffer for OCR result words: pushes from the receive unit, newest-first reads
// to the HPS over a four-phase rd_req/rd_ack handshake, with occupancy and sticky error flags.
module ocr_result_filo #(
  parameter int                 DEPTH      = 16,
  parameter int                 WORD_W     = 32,
  parameter int                 CNT_W      = $clog2(DEPTH + 1),
  parameter logic [WORD_W-1:0]  EMPTY_WORD = '0
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              push_filo,
  input  logic [WORD_W-1:0] data_to_FILO,
  input  logic              Clear_buff,
  input  logic              rd_req,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_ack,
  output logic [CNT_W-1:0]  word_count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    sp_q, sp_d;
  logic [WORD_W-1:0]   rd_data_q, rd_data_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  logic                pop;
  logic                push;
  logic                mem_we;
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       rd_addr;

  assign empty      = (sp_q == '0);
  assign full       = (sp_q == CNT_W'(DEPTH));
  assign word_count = sp_q;
  assign rd_data    = rd_data_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  // A clear blocks both a new pop (deferred in IDLE) and any push in the same cycle.
  assign pop     = (state_q == IDLE) && rd_req && !Clear_buff;
  assign push    = push_filo && !Clear_buff;
  assign wr_addr = AW'(sp_q);
  assign rd_addr = AW'(sp_q - CNT_W'(1));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pop)     state_d = ACK;
      ACK:  if (!rd_req) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ack = (state_q == ACK);
  end

  always_comb begin
    sp_d        = sp_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    if (Clear_buff) begin
      sp_d        = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (pop && push) begin
      // Bypass: the incoming word is handed straight out, the stack is untouched.
      rd_data_d = data_to_FILO;
    end else if (pop) begin
      if (empty) begin
        rd_data_d   = EMPTY_WORD;
        underflow_d = 1'b1;
      end else begin
        rd_data_d = mem_q[rd_addr];
        sp_d      = sp_q - CNT_W'(1);
      end
    end else if (push) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        sp_d   = sp_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; only sp decides which entries are valid.
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      mem_q[wr_addr] <= data_to_FILO;
    end
  end

endmodule

// File: tb/tb_ocr_result_filo.sv
// Bench for ocr_result_filo: a queue-based stack model predicts every read, and a
// scoreboard queue holds expected rd_data until the DUT acknowledges.
module tb_ocr_result_filo;

  localparam int DEPTH  = 16;
  localparam int WORD_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic              push_filo;
  logic [WORD_W-1:0] data_to_FILO;
  logic              Clear_buff;
  logic              rd_req;
  logic [WORD_W-1:0] rd_data;
  logic              rd_ack;
  logic [CNT_W-1:0]  word_count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  int checks   = 0;
  int failures = 0;

  logic [WORD_W-1:0] model[$];
  logic [WORD_W-1:0] exp_q[$];
  logic              exp_ovf;
  logic              exp_unf;

  ocr_result_filo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .push_filo    (push_filo),
    .data_to_FILO (data_to_FILO),
    .Clear_buff   (Clear_buff),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_ack       (rd_ack),
    .word_count   (word_count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, 32'(word_count), 32'(model.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(model.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(model.size() == DEPTH));
    chk({tag, "_ovf"},   32'(overflow),  32'(exp_ovf));
    chk({tag, "_unf"},   32'(underflow), 32'(exp_unf));
  endtask

  task automatic push(input logic [WORD_W-1:0] w);
    push_filo    = 1'b1;
    data_to_FILO = w;
    if (model.size() < DEPTH) model.push_back(w);
    else                      exp_ovf = 1'b1;
    step();
    push_filo = 1'b0;
  endtask

  task automatic clear();
    Clear_buff = 1'b1;
    model.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    step();
    Clear_buff = 1'b0;
  endtask

  // Full four-phase read; the expectation is queued as the request is raised.
  task automatic read(input string tag);
    if (model.size() > 0) exp_q.push_back(model.pop_back());
    else begin
      exp_q.push_back('0);
      exp_unf = 1'b1;
    end
    rd_req = 1'b1;
    step();
    chk({tag, "_ack_rise"}, 32'(rd_ack), 32'd1);
    if (rd_ack) chk({tag, "_data"}, rd_data, exp_q.pop_front());
    else        void'(exp_q.pop_front());
    rd_req = 1'b0;
    step();
    chk({tag, "_ack_fall"}, 32'(rd_ack), 32'd0);
  endtask

  initial begin
    logic [WORD_W-1:0] held;
    rst_n        = 1'b0;
    push_filo    = 1'b0;
    data_to_FILO = '0;
    Clear_buff   = 1'b0;
    rd_req       = 1'b0;
    exp_ovf      = 1'b0;
    exp_unf      = 1'b0;
    step();
    step();
    chk("rst_ack",  32'(rd_ack), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    check_status("rst");
    rst_n = 1'b1;
    step();

    // Basic LIFO order
    push(32'h31); push(32'h32); push(32'h33);
    check_status("t1_fill");
    for (int i = 0; i < 3; i++) begin
      read("t1_rd");
      check_status("t1_after");
    end

    // Overflow
    for (int i = 0; i <= DEPTH; i++) push(WORD_W'(i));
    check_status("t2_full");
    read("t2_rd");
    check_status("t2_after");
    clear();
    check_status("t2_clr");

    // Underflow and its clear
    read("t3_rd");
    check_status("t3_unf");
    clear();
    check_status("t3_clr");

    // Bypass: push coincident with the read request
    push(32'hA);
    push_filo    = 1'b1;
    data_to_FILO = 32'hB;
    rd_req       = 1'b1;
    exp_q.push_back(32'hB);
    step();
    push_filo = 1'b0;
    chk("t4_ack",  32'(rd_ack), 32'd1);
    chk("t4_data", rd_data, exp_q.pop_front());
    check_status("t4");
    rd_req = 1'b0;
    step();
    chk("t4_ack_fall", 32'(rd_ack), 32'd0);
    clear();

    // Held request yields exactly one pop
    push(32'h51); push(32'h52); push(32'h53);
    exp_q.push_back(model.pop_back());
    rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_ack_held", 32'(rd_ack), 32'd1);
    end
    chk("t5_data", rd_data, exp_q.pop_front());
    check_status("t5");
    rd_req = 1'b0;
    step();
    chk("t5_ack_fall", 32'(rd_ack), 32'd0);
    clear();

    // Clear while acknowledging
    for (int i = 0; i < 4; i++) push(32'h60 + 32'(i));
    held = model.pop_back();
    rd_req = 1'b1;
    step();
    chk("t6_data", rd_data, held);
    Clear_buff = 1'b1;
    model.delete();
    step();
    Clear_buff = 1'b0;
    check_status("t6_clr");
    chk("t6_data_kept", rd_data, held);
    chk("t6_ack_kept", 32'(rd_ack), 32'd1);
    step();
    chk("t6_ack_still", 32'(rd_ack), 32'd1);
    rd_req = 1'b0;
    step();
    chk("t6_ack_fall", 32'(rd_ack), 32'd0);

    // Asynchronous reset mid-handshake, with a sticky flag set beforehand
    for (int i = 0; i <= DEPTH; i++) push(32'h70 + 32'(i));
    chk("t7_ovf_pre", 32'(overflow), 32'd1);
    rd_req = 1'b1;
    step();
    chk("t7_ack_pre", 32'(rd_ack), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    chk("t7_ack_async", 32'(rd_ack), 32'd0);
    chk("t7_data", rd_data, 32'd0);
    check_status("t7");
    rd_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    read("t7_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
